// File: rtl/mult_seq.sv
// Sequential shift-add unsigned multiplier: consumes one multiplier bit per clock,
// start/ready/done_tick handshake matching the restoring divider.
module mult_seq #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     multiplicand,
    input  logic [W-1:0]     multiplier,
    output logic [2*W-1:0]   product,
    output logic             ready,
    output logic             done_tick
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OP     = 2'd1,
        DONE   = 2'd2,
        UNUSED = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    mcand_reg, mcand_next;
    logic [W-1:0]    acc_hi, acc_hi_next;
    logic [W-1:0]    acc_lo, acc_lo_next;
    logic [N-1:0]    n_reg, n_next;
    logic [W:0]      sum;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            mcand_reg <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            n_reg     <= '0;
        end else begin
            state_reg <= state_next;
            mcand_reg <= mcand_next;
            acc_hi    <= acc_hi_next;
            acc_lo    <= acc_lo_next;
            n_reg     <= n_next;
        end
    end

    // Next-state, datapath and handshake decode
    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        acc_hi_next = acc_hi;
        acc_lo_next = acc_lo;
        n_next      = n_reg;
        ready       = 1'b0;
        done_tick   = 1'b0;
        // Partial sum keeps the carry so the shifted-in MSB is never lost
        sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand_reg} : {(W+1){1'b0}});

        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    mcand_next  = multiplicand;
                    acc_hi_next = '0;
                    acc_lo_next = multiplier;
                    n_next      = N'(W);
                    state_next  = OP;
                end
            end
            OP: begin
                acc_hi_next = sum[W:1];
                acc_lo_next = {sum[0], acc_lo[W-1:1]};
                n_next      = n_reg - N'(1);
                if (n_reg == N'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_tick  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign product = {acc_hi, acc_lo};

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq (W=32): directed corner cases plus randomized
// operands against a 64-bit arithmetic reference.
module tb_mult_seq;

    localparam int unsigned W = 32;
    localparam int unsigned N = 6;

    logic            clk;
    logic            reset;
    logic            start;
    logic [W-1:0]    multiplicand;
    logic [W-1:0]    multiplier;
    logic [2*W-1:0]  product;
    logic            ready;
    logic            done_tick;

    int tests_run;
    int tests_failed;

    mult_seq #(.W(W), .N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .ready        (ready),
        .done_tick    (done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Launch one multiply from idle (called at a negedge), wait for done, check
    // latency, product, pulse width and return to ready.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int edges;
        check({tag, "_ready_before"}, 64'(ready), 64'd1);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check({tag, "_busy"}, 64'(ready), 64'd0);
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done_tick) break;
        end
        check({tag, "_latency"}, 64'(edges), 64'(W));
        check({tag, "_product"}, product, exp);
        @(negedge clk);
        check({tag, "_done_width"}, 64'(done_tick), 64'd0);
        check({tag, "_ready_after"}, 64'(ready), 64'd1);
        check({tag, "_product_held"}, product, exp);
    endtask

    initial begin
        logic [31:0] a_log [0:101];
        logic [31:0] b_log [0:101];
        logic [31:0] ra, rb;
        int          rel;
        int          saw_done;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_product", product, 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done_tick), 64'd0);

        // Directed cases
        do_op("basic", 32'd123456, 32'd789, 64'd97406784);
        do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        do_op("a_zero", 32'd0, 32'hDEAD_BEEF, 64'd0);
        do_op("b_zero", 32'h1234, 32'd0, 64'd0);
        do_op("one", 32'd1, 32'h8000_0001, 64'h0000_0000_8000_0001);

        // Reset pulse in the middle of an operation aborts it
        multiplicand = 32'hCAFE_F00D;
        multiplier   = 32'h1234_5678;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_product", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_tick) saw_done++;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_idle", 64'(ready), 64'd1);

        // start held high, operands changing every cycle: accepts every W+2 edges
        for (int e = 0; e < 102; e++) begin
            ra = $urandom;
            rb = $urandom;
            a_log[e]     = ra;
            b_log[e]     = rb;
            multiplicand = ra;
            multiplier   = rb;
            start        = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rel = e % (W + 2);
            if (rel == W) begin
                check("cont_done", 64'(done_tick), 64'd1);
                check("cont_product", product, ref_mul(a_log[e - W], b_log[e - W]));
            end else if (done_tick !== 1'b0) begin
                check("cont_spurious_done", 64'(done_tick), 64'd0);
            end
            if (rel == W + 1) check("cont_ready", 64'(ready), 64'd1);
        end
        start = 1'b0;
        @(negedge clk);
        check("cont_idle", 64'(ready), 64'd1);

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 0) ra = 32'hFFFF_FFFF;
            if (i % 70 == 0) rb = 32'hFFFF_FFFF;
            do_op("rand", ra, rb, ref_mul(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
